// File: rtl/sysreg_pkg.sv
// sysreg_pkg: shared constants and types for the sysreg_bank register block.
//   - Register address map (8-bit constants; the bank zero-extends its address).
//   - Key/enable FSM state encoding, also visible on the 0x3 readback.
//   - Status register bit positions and a helper that assembles the status byte.
package sysreg_pkg;

  localparam logic [7:0] ADDR_ID0          = 8'h00;
  localparam logic [7:0] ADDR_ID1          = 8'h01;
  localparam logic [7:0] ADDR_ENABLES      = 8'h02;
  localparam logic [7:0] ADDR_FSM          = 8'h03;
  localparam logic [7:0] ADDR_LAST_ADDR    = 8'h04;
  localparam logic [7:0] ADDR_LAST_DATA    = 8'h05;
  localparam logic [7:0] ADDR_WCOUNT       = 8'h06;
  localparam logic [7:0] ADDR_STATUS       = 8'h07;
  localparam logic [7:0] ADDR_SCRATCH_BASE = 8'h08;

  typedef enum logic [1:0] {
    KEY_OPEN     = 2'd0,
    KEY_LOCKED   = 2'd1,
    KEY_KEY1     = 2'd2,
    KEY_UNLOCKED = 2'd3
  } key_state_e;

  localparam int STATUS_ACTIVE  = 0;
  localparam int STATUS_IGNORED = 1;
  localparam int STATUS_REARM   = 2;

  // Status byte: bit0 live "FSM not open", bits[2:1] sticky flags, rest zero.
  function automatic logic [7:0] status_byte(input logic [1:0] sticky, input logic active);
    status_byte = {5'b00000, sticky, active};
  endfunction

endpackage

// File: rtl/sysreg_key_fsm.sv
// sysreg_key_fsm: write-once enable register guarded by a two-byte re-arm key.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   write_strobe      one-cycle write request from the bank
//   wr_addr, wr_data  zero-extended write address and write data
//   enables           latched enable bits
//   state             current FSM state (OPEN/LOCKED/KEY1/UNLOCKED)
//   ignored_set       pulse: a write to the enables register was refused
//   rearm_set         pulse: the enables register was rewritten after the key
module sysreg_key_fsm
  import sysreg_pkg::*;
#(
  parameter int          NUM_ENABLES = 1,
  parameter logic [7:0]  KEY_A       = 8'h55,
  parameter logic [7:0]  KEY_B       = 8'hAA
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_strobe,
  input  logic [7:0]             wr_addr,
  input  logic [7:0]             wr_data,
  output logic [NUM_ENABLES-1:0] enables,
  output key_state_e             state,
  output logic                   ignored_set,
  output logic                   rearm_set
);

  key_state_e state_r;
  key_state_e state_nxt_s;
  logic       en_load_s;
  logic       wr_en_s;
  logic       wr_key_s;

  assign wr_en_s  = write_strobe && (wr_addr == ADDR_ENABLES);
  assign wr_key_s = write_strobe && (wr_addr == ADDR_FSM);

  // Next-state and set-pulse decode; only enables/key writes move the FSM, except that KEY1 falls back on any other write.
  always_comb begin
    state_nxt_s = state_r;
    en_load_s   = 1'b0;
    ignored_set = 1'b0;
    rearm_set   = 1'b0;
    case (state_r)
      KEY_OPEN: begin
        if (wr_en_s) begin
          en_load_s   = 1'b1;
          state_nxt_s = KEY_LOCKED;
        end else begin
          state_nxt_s = KEY_OPEN;
        end
      end
      KEY_LOCKED: begin
        if (wr_en_s) begin
          ignored_set = 1'b1;
        end else if (wr_key_s && (wr_data == KEY_A)) begin
          state_nxt_s = KEY_KEY1;
        end else begin
          state_nxt_s = KEY_LOCKED;
        end
      end
      KEY_KEY1: begin
        if (wr_key_s && (wr_data == KEY_B)) begin
          state_nxt_s = KEY_UNLOCKED;
        end else if (write_strobe) begin
          state_nxt_s = KEY_LOCKED;
          ignored_set = wr_en_s;
        end else begin
          state_nxt_s = KEY_KEY1;
        end
      end
      KEY_UNLOCKED: begin
        if (wr_en_s) begin
          en_load_s   = 1'b1;
          rearm_set   = 1'b1;
          state_nxt_s = KEY_LOCKED;
        end else begin
          state_nxt_s = KEY_UNLOCKED;
        end
      end
      default: begin
        state_nxt_s = KEY_OPEN;
      end
    endcase
  end

  // FSM state and enables register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= KEY_OPEN;
      enables <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (en_load_s) begin
        enables <= wr_data[NUM_ENABLES-1:0];
      end
    end
  end

  assign state = state_r;

endmodule

// File: rtl/sysreg_bank.sv
// sysreg_bank: 8-bit system register bank behind the core's register decoder.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   a              register address
//   d_d            write data
//   d_q            registered read data, updated one cycle after read_strobe
//   read_strobe    one-cycle read request
//   write_strobe   one-cycle write request
//   enables        write-once enable bits (re-armed by the KEY_A/KEY_B sequence)
module sysreg_bank
  import sysreg_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 4,
  parameter int          NUM_SCRATCH = 2,
  parameter int          NUM_ENABLES = 1,
  parameter logic [7:0]  ID0         = 8'h42,
  parameter logic [7:0]  ID1         = 8'h73,
  parameter logic [7:0]  KEY_A       = 8'h55,
  parameter logic [7:0]  KEY_B       = 8'hAA
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  a,
  input  logic [7:0]             d_d,
  output logic [7:0]             d_q,
  input  logic                   read_strobe,
  input  logic                   write_strobe,
  output logic [NUM_ENABLES-1:0] enables
);

  logic [7:0]            a_ext_s;
  logic [ADDR_WIDTH-1:0] last_addr_r;
  logic [7:0]            last_data_r;
  logic [7:0]            wcount_r;
  logic [1:0]            sticky_r;
  logic [7:0]            scratch_r [NUM_SCRATCH];
  logic [7:0]            rd_data_s;
  logic [7:0]            scratch_rd_s;
  logic                  scratch_hit_s;
  logic                  status_clr_s;
  key_state_e            state_s;
  logic                  ignored_set_s;
  logic                  rearm_set_s;

  assign a_ext_s      = {{(8 - ADDR_WIDTH){1'b0}}, a};
  assign status_clr_s = read_strobe && (a_ext_s == ADDR_STATUS);

  sysreg_key_fsm #(
    .NUM_ENABLES (NUM_ENABLES),
    .KEY_A       (KEY_A),
    .KEY_B       (KEY_B)
  ) u_key_fsm (
    .clk          (clk),
    .reset        (reset),
    .write_strobe (write_strobe),
    .wr_addr      (a_ext_s),
    .wr_data      (d_d),
    .enables      (enables),
    .state        (state_s),
    .ignored_set  (ignored_set_s),
    .rearm_set    (rearm_set_s)
  );

  // Scratch read select; at most one entry can match the address.
  always_comb begin
    scratch_hit_s = 1'b0;
    scratch_rd_s  = 8'h00;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_hit_s = scratch_hit_s | (a_ext_s == (ADDR_SCRATCH_BASE + 8'(i)));
      scratch_rd_s  = scratch_rd_s |
                      ((a_ext_s == (ADDR_SCRATCH_BASE + 8'(i))) ? scratch_r[i] : 8'h00);
    end
  end

  // Read mux over the pre-update register values.
  always_comb begin
    rd_data_s = 8'hFF;
    case (a_ext_s)
      ADDR_ID0:       rd_data_s = ID0;
      ADDR_ID1:       rd_data_s = ID1;
      ADDR_ENABLES:   rd_data_s = 8'(enables);
      ADDR_FSM:       rd_data_s = {6'b000000, state_s};
      ADDR_LAST_ADDR: rd_data_s = {{(8 - ADDR_WIDTH){1'b0}}, last_addr_r};
      ADDR_LAST_DATA: rd_data_s = last_data_r;
      ADDR_WCOUNT:    rd_data_s = wcount_r;
      ADDR_STATUS:    rd_data_s = status_byte(sticky_r, state_s != KEY_OPEN);
      default:        rd_data_s = scratch_hit_s ? scratch_rd_s : 8'hFF;
    endcase
  end

  // Read data register, capture registers, write counter and sticky status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q         <= 8'hFF;
      last_addr_r <= '0;
      last_data_r <= 8'h00;
      wcount_r    <= 8'h00;
      sticky_r    <= 2'b00;
    end else begin
      if (read_strobe) begin
        d_q <= rd_data_s;
      end
      if (write_strobe) begin
        last_addr_r <= a;
        last_data_r <= d_d;
        wcount_r    <= wcount_r + 8'd1;
      end
      // A new set in the same cycle as a read-clear survives the clear.
      sticky_r <= (status_clr_s ? 2'b00 : sticky_r) | {rearm_set_s, ignored_set_s};
    end
  end

  // Scratch registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_r[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (write_strobe && (a_ext_s == (ADDR_SCRATCH_BASE + 8'(i)))) begin
          scratch_r[i] <= d_d;
        end
      end
    end
  end

endmodule
